jtopll_mmr_q: RTL and testbench

Parametrised CPU-side register front-end for the OPLL family. It latches address and data writes for one or two register banks, decodes channel and instrument writes into update records, and buffers them in a write queue. Records are released to the register file through a valid/ack handshake qualified by `cenop`. Global rhythm/LFO bits are applied immediately, and a status byte reports queue state and, optionally, chip-style busy.

---
 rtl/jtopll_mmr_pkg.sv | 33 +++
 rtl/jtopll_wrq.sv | 53 +++++
 rtl/jtopll_mmr_q.sv | 160 ++++++++++++++++
 tb/tb_jtopll_mmr_q.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopll_mmr_pkg.sv
// Shared types for the OPLL CPU register front-end.
//   up_kind_e : kind of a queued update record
//   up_rec_t  : queued update record {bank, kind, group, sub, data}
//   REG_RHYTHM: selector value of the rhythm/LFO global register
package jtopll_mmr_pkg;

    typedef enum logic [1:0] {
        UP_ORIG   = 2'd0,
        UP_FNUMLO = 2'd1,
        UP_FNUMHI = 2'd2,
        UP_INST   = 2'd3
    } up_kind_e;

    localparam logic [7:0] REG_RHYTHM = 8'h0E;

    typedef struct packed {
        logic        bank;
        up_kind_e    kind;
        logic [1:0]  group;
        logic [2:0]  sub;
        logic [7:0]  data;
    } up_rec_t;

    localparam int unsigned REC_W = $bits(up_rec_t);

    // Channel group of a per-channel register: three channels per group.
    function automatic logic [1:0] chan_group(input logic [3:0] lo);
        if (lo < 4'd3)      return 2'd0;
        else if (lo < 4'd6) return 2'd1;
        else                return 2'd2;
    endfunction

endpackage

// File: rtl/jtopll_wrq.sv
// Generic synchronous FIFO for the register write queue.
//   clk, rst   : clock, asynchronous active-high reset (clears pointers and storage)
//   push_i     : store wdata_i; accepted when not full, or when full and a pop happens
//   pop_i      : drop the head; ignored when empty
//   rdata_o    : head entry, read combinationally from storage
//   full_o     : Depth entries held
//   empty_o    : no entries held
module jtopll_wrq #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]      wr_q, rd_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= wdata_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtopll_mmr_q.sv
// CPU-side register front-end for the OPLL family.
// Latches address/data writes for one or two banks, decodes channel and
// instrument writes into update records queued in jtopll_wrq, and applies
// the rhythm/LFO global register immediately.
//   clk, rst        : clock, asynchronous active-high reset
//   cen, cenop      : chip clock enable, operator-rate enable (qualifies up_ack)
//   din, addr, write: CPU bus; addr[0] 0=address 1=data, addr[1] bank
//   dout            : status {busy, overflow, full, 5'b0}
//   rhy_en, am_dep, vib_dep, rhy_kon : global bits
//   up_valid/up_ack : queue head handshake; up_kind/bank/group/sub/data = head record
//   overflow        : sticky, a record was dropped on a full queue
// Build option: define JTOPLL_MMR_BUSY_EN to build the chip-style busy counter.
module jtopll_mmr_q
    import jtopll_mmr_pkg::*;
#(
    parameter int unsigned BANKS    = 1,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned BUSY_CYC = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cenop,
    input  logic [7:0] din,
    input  logic [1:0] addr,
    input  logic       write,
    output logic [7:0] dout,
    output logic       rhy_en,
    output logic       am_dep,
    output logic       vib_dep,
    output logic [4:0] rhy_kon,
    output logic       up_valid,
    input  logic       up_ack,
    output logic [1:0] up_kind,
    output logic       up_bank,
    output logic [1:0] up_group,
    output logic [2:0] up_sub,
    output logic [7:0] up_data,
    output logic       overflow
);

    logic       bank;
    logic [7:0] sel_q [2];
    logic [7:0] sel;
    logic [3:0] lo, hi, lo_m6;
    logic       wr_addr, wr_data;
    logic       push, pop, full, empty, rhy_we, busy;
    logic       overflow_q;
    up_rec_t    rec, head;

    assign bank    = (BANKS == 2) ? addr[1] : 1'b0;
    assign wr_addr = write & ~addr[0];
    assign wr_data = write &  addr[0];
    assign sel     = sel_q[bank];
    assign lo      = sel[3:0];
    assign hi      = sel[7:4];
    assign lo_m6   = lo - 4'd6;

    // Record decode of a data write against the bank's selector.
    always_comb begin
        rec       = '0;
        rec.bank  = bank;
        rec.kind  = UP_ORIG;
        rec.data  = din;
        push      = 1'b0;
        rhy_we    = 1'b0;
        if (wr_data) begin
            if (!bank && sel < 8'd8) begin
                push    = 1'b1;
                rec.sub = sel[2:0];
            end else if (hi != 4'd0 && hi <= 4'd3 && lo <= 4'd8) begin
                push      = 1'b1;
                rec.kind  = up_kind_e'(hi[1:0]);
                rec.group = chan_group(lo);
                rec.sub   = (lo < 4'd6) ? lo[2:0] : lo_m6[2:0];
            end else if (!bank && sel == REG_RHYTHM) begin
                rhy_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q[0]   <= '0;
            sel_q[1]   <= '0;
            am_dep     <= 1'b0;
            vib_dep    <= 1'b0;
            rhy_en     <= 1'b0;
            rhy_kon    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_addr) begin
                sel_q[bank] <= din;
            end
            if (rhy_we) begin
                am_dep  <= din[7];
                vib_dep <= din[6];
                rhy_en  <= din[5];
                rhy_kon <= din[4:0];
            end
            // A full queue only makes room when the head leaves in the same clk.
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign up_valid = ~empty;
    assign pop      = up_valid & up_ack & cenop;

    jtopll_wrq #(
        .Width (REC_W),
        .Depth (QDEPTH)
    ) u_wrq (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (rec),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign up_kind  = head.kind;
    assign up_bank  = head.bank;
    assign up_group = head.group;
    assign up_sub   = head.sub;
    assign up_data  = head.data;
    assign overflow = overflow_q;

`ifdef JTOPLL_MMR_BUSY_EN
    localparam int unsigned BW = $clog2(BUSY_CYC + 1);

    logic [BW-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (wr_data) begin
            busy_d = BW'(BUSY_CYC);
        end else if (cen && busy_q != '0) begin
            busy_d = busy_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy = (busy_q != '0);
`else
    logic unused_cen;
    assign unused_cen = cen;
    assign busy       = 1'b0;
`endif

    assign dout = {busy, overflow_q, full, 5'b0};

endmodule

// File: tb/tb_jtopll_mmr_q.sv
module tb_jtopll_mmr_q;
    import jtopll_mmr_pkg::*;

    localparam int unsigned BANKS    = 2;
    localparam int unsigned QDEPTH   = 4;
    localparam int unsigned BUSY_CYC = 12;
`ifdef JTOPLL_MMR_BUSY_EN
    localparam bit BUSY_ON = 1'b1;
`else
    localparam bit BUSY_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, cen, cenop, write, up_ack;
    logic [7:0] din;
    logic [1:0] addr;
    logic [7:0] dout;
    logic       rhy_en, am_dep, vib_dep, up_valid, up_bank, overflow;
    logic [4:0] rhy_kon;
    logic [1:0] up_kind, up_group;
    logic [2:0] up_sub;
    logic [7:0] up_data;

    jtopll_mmr_q #(
        .BANKS    (BANKS),
        .QDEPTH   (QDEPTH),
        .BUSY_CYC (BUSY_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .cenop    (cenop),
        .din      (din),
        .addr     (addr),
        .write    (write),
        .dout     (dout),
        .rhy_en   (rhy_en),
        .am_dep   (am_dep),
        .vib_dep  (vib_dep),
        .rhy_kon  (rhy_kon),
        .up_valid (up_valid),
        .up_ack   (up_ack),
        .up_kind  (up_kind),
        .up_bank  (up_bank),
        .up_group (up_group),
        .up_sub   (up_sub),
        .up_data  (up_data),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]  m_sel [2];
    logic [15:0] m_q [$];
    logic        m_ovf, m_am, m_vib, m_rhy;
    logic [4:0]  m_kon;
    int          m_busy;

    wire [15:0] head = {up_bank, up_kind, up_group, up_sub, up_data};

    // Record a data write produces, from the register map arithmetic.
    function automatic bit m_decode(input logic b, input logic [7:0] s, input logic [7:0] d,
                                    output logic [15:0] rec);
        int lo, hi;
        logic [1:0] k, g;
        logic [2:0] sb;
        lo  = int'(s) % 16;
        hi  = int'(s) / 16;
        rec = '0;
        if (!b && s < 8) begin
            sb  = s[2:0];
            rec = {1'b0, 2'd0, 2'd0, sb, d};
            return 1'b1;
        end
        if (hi >= 1 && hi <= 3 && lo <= 8) begin
            k   = 2'(hi);
            g   = 2'(lo / 3);
            sb  = 3'(lo % 6);
            rec = {b, k, g, sb, d};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] m_dout();
        return {BUSY_ON && (m_busy != 0), m_ovf, m_q.size() == QDEPTH, 5'b0};
    endfunction

    task automatic m_reset();
        m_sel[0] = '0; m_sel[1] = '0;
        m_q.delete();
        m_ovf = 0; m_am = 0; m_vib = 0; m_rhy = 0; m_kon = '0; m_busy = 0;
    endtask

    // One clock with the given inputs; model follows the same edge.
    task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d,
                        input logic ack, input logic cop, input logic ce);
        logic [15:0] rec;
        bit ok, pop;
        logic b;
        b = a[1];
        write = w; addr = a; din = d; up_ack = ack; cenop = cop; cen = ce;
        pop = (m_q.size() > 0) && ack && cop;
        ok  = 1'b0;
        if (w && a[0]) begin
            ok = m_decode(b, m_sel[b], d, rec);
            if (!b && m_sel[b] == REG_RHYTHM) begin
                m_am = d[7]; m_vib = d[6]; m_rhy = d[5]; m_kon = d[4:0];
            end
            m_busy = BUSY_CYC;
        end else if (ce && m_busy > 0) begin
            m_busy--;
        end
        if (w && !a[0]) m_sel[b] = d;
        if (pop) void'(m_q.pop_front());
        if (ok) begin
            if (m_q.size() < QDEPTH) m_q.push_back(rec);
            else                     m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        write = 0; up_ack = 0; cenop = 0; cen = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        write = 0; up_ack = 0; cenop = 0; cen = 0; din = '0; addr = '0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        write = 0; up_ack = 0; cenop = 0; cen = 0; din = '0; addr = '0;
        m_reset();
        #12;
        n_checks++;
        if (dout !== 8'h00) begin
            n_errors++; $display("FAIL reset_dout: got %h want 00", dout);
        end
        n_checks++;
        if ({up_valid, overflow} !== 2'b00) begin
            n_errors++; $display("FAIL reset_valid_ovf: got %b want 00", {up_valid, overflow});
        end
        n_checks++;
        if (head !== 16'h0000) begin
            n_errors++; $display("FAIL reset_head: got %h want 0000", head);
        end
        n_checks++;
        if ({am_dep, vib_dep, rhy_en, rhy_kon} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_globals: got %h want 00", {am_dep, vib_dep, rhy_en, rhy_kon});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 2'b01, 8'h11, 0, 0, 0);
        step(1, 2'b01, 8'h22, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({up_valid, dout} !== 9'h000) begin
            n_errors++;
            $display("FAIL async_reset: got valid=%b dout=%h want valid=0 dout=00", up_valid, dout);
        end
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_decode();
        do_reset();
        step(1, 2'b00, 8'h10, 0, 0, 0);
        step(1, 2'b01, 8'h55, 0, 0, 0);
        n_checks++;
        if ({up_valid, head} !== {1'b1, 1'b0, 2'd1, 2'd0, 3'd0, 8'h55}) begin
            n_errors++;
            $display("FAIL fnumlo_rec: got valid=%b rec=%h want valid=1 rec=%h",
                     up_valid, head, {1'b0, 2'd1, 2'd0, 3'd0, 8'h55});
        end
        n_checks++;
        if (dout !== (BUSY_ON ? 8'h80 : 8'h00)) begin
            n_errors++; $display("FAIL fnumlo_dout: got %h want %h", dout, BUSY_ON ? 8'h80 : 8'h00);
        end
        // ack without cenop, and cenop without ack, must not pop
        step(0, 2'b00, 8'h00, 1, 0, 0);
        step(0, 2'b00, 8'h00, 0, 1, 0);
        n_checks++;
        if ({up_valid, up_data} !== {1'b1, 8'h55}) begin
            n_errors++;
            $display("FAIL ack_qualify: got valid=%b data=%h want valid=1 data=55", up_valid, up_data);
        end
        step(0, 2'b00, 8'h00, 1, 1, 0);
        n_checks++;
        if (up_valid !== 1'b0) begin
            n_errors++; $display("FAIL pop_empty: got valid=%b want 0", up_valid);
        end
        step(1, 2'b00, 8'h37, 0, 0, 0);
        step(1, 2'b01, 8'hA3, 0, 0, 0);
        n_checks++;
        if ({up_valid, head} !== {1'b1, 1'b0, 2'd3, 2'd2, 3'd1, 8'hA3}) begin
            n_errors++;
            $display("FAIL inst_rec: got valid=%b rec=%h want valid=1 rec=%h",
                     up_valid, head, {1'b0, 2'd3, 2'd2, 3'd1, 8'hA3});
        end
        step(0, 2'b00, 8'h00, 1, 1, 0);
        step(1, 2'b00, 8'h19, 0, 0, 0);
        step(1, 2'b01, 8'h44, 0, 0, 0);
        n_checks++;
        if ({up_valid, overflow} !== 2'b00) begin
            n_errors++;
            $display("FAIL ignored_sel: got valid=%b ovf=%b want 0 0", up_valid, overflow);
        end
    endtask

    task automatic test_rhythm();
        do_reset();
        step(1, 2'b00, REG_RHYTHM, 0, 0, 0);
        step(1, 2'b01, 8'hE5, 0, 0, 0);
        n_checks++;
        if ({am_dep, vib_dep, rhy_en, rhy_kon, up_valid} !== {3'b111, 5'h05, 1'b0}) begin
            n_errors++;
            $display("FAIL rhythm_set: got am=%b vib=%b rhy=%b kon=%h valid=%b want 1 1 1 05 0",
                     am_dep, vib_dep, rhy_en, rhy_kon, up_valid);
        end
        step(1, 2'b01, 8'h0A, 0, 0, 0);
        n_checks++;
        if ({am_dep, vib_dep, rhy_en, rhy_kon} !== {3'b000, 5'h0A}) begin
            n_errors++;
            $display("FAIL rhythm_clr: got %h want 0a", {am_dep, vib_dep, rhy_en, rhy_kon});
        end
    endtask

    task automatic test_overflow();
        do_reset();
        step(1, 2'b00, 8'h21, 0, 0, 0);
        for (int i = 0; i <= QDEPTH; i++) step(1, 2'b01, 8'(8'h40 + i), 0, 0, 0);
        n_checks++;
        if ({dout[6:5], overflow} !== 3'b111) begin
            n_errors++;
            $display("FAIL overflow_flags: got dout=%h ovf=%b want dout[6:5]=11 ovf=1", dout, overflow);
        end
        for (int i = 0; i < QDEPTH; i++) begin
            n_checks++;
            if ({up_valid, head} !== {1'b1, 1'b0, 2'd2, 2'd0, 3'd1, 8'(8'h40 + i)}) begin
                n_errors++;
                $display("FAIL overflow_drain%0d: got valid=%b rec=%h want valid=1 rec=%h", i,
                         up_valid, head, {1'b0, 2'd2, 2'd0, 3'd1, 8'(8'h40 + i)});
            end
            step(0, 2'b00, 8'h00, 1, 1, 0);
        end
        n_checks++;
        if ({up_valid, overflow, dout[5]} !== 3'b010) begin
            n_errors++;
            $display("FAIL overflow_sticky: got valid=%b ovf=%b full=%b want 0 1 0",
                     up_valid, overflow, dout[5]);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        step(1, 2'b00, 8'h33, 0, 0, 0);
        for (int i = 0; i < QDEPTH; i++) step(1, 2'b01, 8'(8'h60 + i), 0, 0, 0);
        n_checks++;
        if ({dout[6:5]} !== 2'b01) begin
            n_errors++; $display("FAIL full_before: got dout=%h want dout[6:5]=01", dout);
        end
        step(1, 2'b01, 8'(8'h60 + QDEPTH), 1, 1, 0);
        n_checks++;
        if ({overflow, dout[5], up_data} !== {1'b0, 1'b1, 8'h61}) begin
            n_errors++;
            $display("FAIL full_push_pop: got ovf=%b full=%b data=%h want 0 1 61",
                     overflow, dout[5], up_data);
        end
        for (int i = 1; i <= QDEPTH; i++) begin
            n_checks++;
            if ({up_valid, head} !== {1'b1, 1'b0, 2'd3, 2'd1, 3'd3, 8'(8'h60 + i)}) begin
                n_errors++;
                $display("FAIL full_drain%0d: got valid=%b rec=%h want valid=1 rec=%h", i,
                         up_valid, head, {1'b0, 2'd3, 2'd1, 3'd3, 8'(8'h60 + i)});
            end
            step(0, 2'b00, 8'h00, 1, 1, 0);
        end
    endtask

    task automatic test_bank1();
        do_reset();
        step(1, 2'b00, 8'h12, 0, 0, 0);
        step(1, 2'b10, 8'h20, 0, 0, 0);
        step(1, 2'b11, 8'h12, 0, 0, 0);
        n_checks++;
        if ({up_valid, head} !== {1'b1, 1'b1, 2'd2, 2'd0, 3'd0, 8'h12}) begin
            n_errors++;
            $display("FAIL bank1_rec: got valid=%b rec=%h want valid=1 rec=%h",
                     up_valid, head, {1'b1, 2'd2, 2'd0, 3'd0, 8'h12});
        end
        step(0, 2'b00, 8'h00, 1, 1, 0);
        step(1, 2'b10, 8'h03, 0, 0, 0);
        step(1, 2'b11, 8'h77, 0, 0, 0);
        step(1, 2'b10, REG_RHYTHM, 0, 0, 0);
        step(1, 2'b11, 8'hFF, 0, 0, 0);
        n_checks++;
        if ({up_valid, overflow, am_dep, rhy_kon} !== 8'h00) begin
            n_errors++;
            $display("FAIL bank1_ignored: got valid=%b ovf=%b am=%b kon=%h want all 0",
                     up_valid, overflow, am_dep, rhy_kon);
        end
        step(1, 2'b01, 8'h99, 0, 0, 0);
        n_checks++;
        if ({up_valid, head} !== {1'b1, 1'b0, 2'd1, 2'd0, 3'd2, 8'h99}) begin
            n_errors++;
            $display("FAIL bank0_sel_kept: got valid=%b rec=%h want valid=1 rec=%h",
                     up_valid, head, {1'b0, 2'd1, 2'd0, 3'd2, 8'h99});
        end
    endtask

    task automatic test_busy();
        do_reset();
        n_checks++;
        if (dout[7] !== 1'b0) begin
            n_errors++; $display("FAIL busy_idle: got %b want 0", dout[7]);
        end
        step(1, 2'b01, 8'h01, 0, 0, 0);
        step(0, 2'b00, 8'h00, 0, 0, 0);
        step(0, 2'b00, 8'h00, 0, 0, 0);
        for (int i = 0; i < BUSY_CYC; i++) begin
            n_checks++;
            if (dout[7] !== BUSY_ON) begin
                n_errors++; $display("FAIL busy_hold%0d: got %b want %b", i, dout[7], BUSY_ON);
            end
            step(0, 2'b00, 8'h00, 0, 0, 1);
        end
        n_checks++;
        if (dout[7] !== 1'b0) begin
            n_errors++; $display("FAIL busy_clear: got %b want 0", dout[7]);
        end
    endtask

    task automatic test_random();
        logic        w, ack, cop, ce;
        logic [1:0]  a;
        logic [7:0]  d;
        logic [17:0] obs, expv;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            w   = ($urandom_range(0, 2) != 0);
            a   = 2'($urandom_range(0, 3));
            ack = ($urandom_range(0, 3) != 0);
            cop = ($urandom_range(0, 3) != 0);
            ce  = $urandom_range(0, 1) != 0;
            if (!a[0]) begin
                case ($urandom_range(0, 5))
                    0:       d = 8'($urandom_range(0, 7));
                    1, 2, 3: d = {4'($urandom_range(1, 3)), 4'($urandom_range(0, 9))};
                    4:       d = REG_RHYTHM;
                    default: d = 8'($urandom);
                endcase
            end else begin
                d = 8'($urandom);
            end
            step(w, a, d, ack, cop, ce);
            obs  = {up_valid, dout, am_dep, vib_dep, rhy_en, rhy_kon};
            expv = {m_q.size() != 0, m_dout(), m_am, m_vib, m_rhy, m_kon};
            n_checks++;
            if (obs !== expv || overflow !== m_ovf) begin
                n_errors++;
                $display("FAIL random_state%0d: got %h ovf=%b want %h ovf=%b",
                         n, obs, overflow, expv, m_ovf);
            end
            if (m_q.size() != 0) begin
                n_checks++;
                if (head !== m_q[0]) begin
                    n_errors++;
                    $display("FAIL random_head%0d: got %h want %h", n, head, m_q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_decode();
        test_rhythm();
        test_overflow();
        test_full_push_pop();
        test_bank1();
        test_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
